// File: rtl/lc2k_regfile_sb_pkg.sv
// lc2k_pkg: shared LC2K widths, index/word types and opcodes used to decide which instructions reserve a destination
package lc2k_pkg;
  localparam int LC2K_DATA_W   = 32;
  localparam int LC2K_NUM_REGS = 8;
  localparam int LC2K_ADDR_W   = 3;
  typedef logic [LC2K_ADDR_W-1:0] reg_idx_t;
  typedef logic [LC2K_DATA_W-1:0] word_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } opcode_t;
  // Decode asserts rsv_en for the instructions that produce a register result through writeback.
  function automatic logic writes_reg(opcode_t op);
    return op inside {OP_ADD, OP_NOR, OP_LW};
  endfunction
endpackage

// File: rtl/lc2k_regfile_sb_if.sv
// lc2k_regfile_sb_if: decode/writeback bus of the LC2K register file
//   master (pipeline): drives read/debug indices, write and reserve requests
//   slave (regfile): returns read data, busy flags and the full scoreboard
interface lc2k_regfile_sb_if
  import lc2k_pkg::*;
#(
  parameter int DATA_W   = LC2K_DATA_W,
  parameter int NUM_REGS = LC2K_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic [ADDR_W-1:0]   rd_addr_a, rd_addr_b, wr_addr, rsv_addr, dbg_addr;
  logic [DATA_W-1:0]   rd_data_a, rd_data_b, wr_data, dbg_data;
  logic                busy_a, busy_b, wr_en, rsv_en;
  logic [NUM_REGS-1:0] busy_vec;
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, dbg_data, busy_vec
  );
  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, dbg_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, dbg_data, busy_vec
  );
endinterface

// File: rtl/lc2k_regfile_sb_scoreboard.sv
// lc2k_scoreboard: per-register busy bits, set by reserve, cleared by writeback, reserve wins on collision
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en_i/addr_i  : writeback clears the busy bit
//   rsv_en_i/addr_i : issue reserves (sets) the busy bit
//   busy_vec_o      : registered scoreboard, bit i = register i busy
module lc2k_scoreboard
  import lc2k_pkg::*;
#(
  parameter int NUM_REGS  = LC2K_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG0 = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic                rsv_en_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  output logic [NUM_REGS-1:0] busy_vec_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  // Indices that hold real state: in range, and not the hardwired zero register.
  localparam logic [DEPTH-1:0] OK = ({DEPTH{1'b1}} >> (DEPTH - NUM_REGS)) & ~DEPTH'(ZERO_REG0 != 0);
  logic [NUM_REGS-1:0] set_w, clr_w, busy_q, busy_d;
  always_comb begin
    set_w  = rsv_en_i ? NUM_REGS'(OK & (DEPTH'(1) << rsv_addr_i)) : '0;
    clr_w  = wr_en_i ? NUM_REGS'(OK & (DEPTH'(1) << wr_addr_i)) : '0;
    busy_d = (busy_q & ~clr_w) | set_w;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_vec_o = busy_q;
endmodule

// File: rtl/lc2k_regfile_sb.sv
// lc2k_regfile_sb: clocked LC2K register file with two combinational read ports, one write port, debug port and busy scoreboard
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lc2k_regfile_sb_if.slave (reads, write, reserve, debug, busy flags)
//   LC2K_REGFILE_BYPASS_EN : when defined, a same-cycle write forwards to read ports A/B and clears their busy
module lc2k_regfile_sb
  import lc2k_pkg::*;
#(
  parameter int DATA_W    = LC2K_DATA_W,
  parameter int NUM_REGS  = LC2K_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG0 = 0
) (
  input logic             clk,
  input logic             rst_n,
  lc2k_regfile_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DEPTH-1:0] OK = ({DEPTH{1'b1}} >> (DEPTH - NUM_REGS)) & ~DEPTH'(ZERO_REG0 != 0);
`ifdef LC2K_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  // Array spans every encodable index; entries outside OK are never written so they stay 0 and read as 0.
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    we, busy_ext;
  logic [NUM_REGS-1:0] busy_vec;
  logic                hit_a, hit_b;
  always_comb begin
    we     = bus.wr_en ? OK & (DEPTH'(1) << bus.wr_addr) : '0;
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) regs_d[i] = we[i] ? bus.wr_data : regs_q[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  lc2k_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG0(ZERO_REG0)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .rsv_en_i  (bus.rsv_en),
    .rsv_addr_i(bus.rsv_addr),
    .busy_vec_o(busy_vec)
  );
  // Forwarding is gated by rst_n so reads stay 0 while reset is held even with a write pending.
  always_comb begin
    busy_ext      = DEPTH'(busy_vec);
    hit_a         = BYPASS && rst_n && bus.wr_en && OK[bus.wr_addr] && (bus.wr_addr == bus.rd_addr_a);
    hit_b         = BYPASS && rst_n && bus.wr_en && OK[bus.wr_addr] && (bus.wr_addr == bus.rd_addr_b);
    bus.rd_data_a = hit_a ? bus.wr_data : regs_q[bus.rd_addr_a];
    bus.rd_data_b = hit_b ? bus.wr_data : regs_q[bus.rd_addr_b];
    bus.busy_a    = !hit_a && busy_ext[bus.rd_addr_a];
    bus.busy_b    = !hit_b && busy_ext[bus.rd_addr_b];
    bus.dbg_data  = regs_q[bus.dbg_addr];
    bus.busy_vec  = busy_vec;
  end
endmodule

// File: tb/tb_lc2k_regfile_sb.sv
// tb_lc2k_regfile_sb: vector table, corner sequences and randomized model check of two register file configurations
module tb_lc2k_regfile_sb;
`ifdef LC2K_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_en = 1'b0, rsv_en = 1'b0;
  logic [2:0]  wr_addr = '0, rsv_addr = '0, rda = '0, rdb = '0, dbg = '0;
  logic [31:0] wr_data = '0;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  lc2k_regfile_sb_if #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3)) b0 ();
  lc2k_regfile_sb_if #(.DATA_W(32), .NUM_REGS(6), .ADDR_W(3)) b1 ();
  assign b0.wr_en = wr_en;      assign b1.wr_en = wr_en;
  assign b0.wr_addr = wr_addr;  assign b1.wr_addr = wr_addr;
  assign b0.wr_data = wr_data;  assign b1.wr_data = wr_data;
  assign b0.rsv_en = rsv_en;    assign b1.rsv_en = rsv_en;
  assign b0.rsv_addr = rsv_addr; assign b1.rsv_addr = rsv_addr;
  assign b0.rd_addr_a = rda;    assign b1.rd_addr_a = rda;
  assign b0.rd_addr_b = rdb;    assign b1.rd_addr_b = rdb;
  assign b0.dbg_addr = dbg;     assign b1.dbg_addr = dbg;
  lc2k_regfile_sb #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG0(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  lc2k_regfile_sb #(.DATA_W(32), .NUM_REGS(6), .ADDR_W(3), .ZERO_REG0(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  typedef struct {
    logic [31:0] we, wa, wd, re, ra, a, b, d, ea, eb, ed, ebv, eba, ebb;
  } vec_t;
  vec_t tbl [12];
  logic [31:0] m_mem [2][8];
  bit          m_busy [2][8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic apply(input logic we, input logic [2:0] wa, input logic [31:0] wd, input logic re, input logic [2:0] ra);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
    @(posedge clk);
    #1 wr_en = 1'b0; rsv_en = 1'b0;
    #1;
  endtask
  function automatic bit okw(int k, int a);
    return a < (k ? 6 : 8) && !(k == 1 && a == 0);
  endfunction
  function automatic bit hit(int k, int a);
    return BYP && wr_en && okw(k, int'(wr_addr)) && int'(wr_addr) == a;
  endfunction
  function automatic logic [31:0] exp_rd(int k, int a);
    return hit(k, a) ? wr_data : m_mem[k][a];
  endfunction
  function automatic logic [31:0] exp_bv(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < (k ? 6 : 8); i++) v[i] = m_busy[k][i];
    return v;
  endfunction
  task automatic chk_model(input int k, input int n);
    chk($sformatf("rnd%0d_i%0d_rd_a", n, k), k ? b1.rd_data_a : b0.rd_data_a, exp_rd(k, int'(rda)));
    chk($sformatf("rnd%0d_i%0d_rd_b", n, k), k ? b1.rd_data_b : b0.rd_data_b, exp_rd(k, int'(rdb)));
    chk($sformatf("rnd%0d_i%0d_busy_a", n, k), 32'(k ? b1.busy_a : b0.busy_a), 32'(!hit(k, int'(rda)) && m_busy[k][rda]));
    chk($sformatf("rnd%0d_i%0d_busy_b", n, k), 32'(k ? b1.busy_b : b0.busy_b), 32'(!hit(k, int'(rdb)) && m_busy[k][rdb]));
    chk($sformatf("rnd%0d_i%0d_dbg", n, k), k ? b1.dbg_data : b0.dbg_data, m_mem[k][dbg]);
    chk($sformatf("rnd%0d_i%0d_busy_vec", n, k), k ? 32'(b1.busy_vec) : 32'(b0.busy_vec), exp_bv(k));
  endtask
  initial begin
    tbl[0]  = '{1, 2, 'h7, 0, 0, 2, 3, 2, 'h7, 0, 'h7, 'h00, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 5, 5, 2, 5, 0, 'h7, 0, 'h20, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 5, 5, 2, 0, 0, 'h7, 'h20, 1, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 2, 5, 5, 'h7, 0, 0, 'h20, 0, 1};
    tbl[4]  = '{1, 5, 'h42, 0, 0, 5, 2, 5, 'h42, 'h7, 'h42, 'h00, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 4, 4, 5, 4, 0, 'h42, 0, 'h10, 1, 0};
    tbl[6]  = '{1, 4, 'h11, 1, 4, 4, 4, 4, 'h11, 'h11, 'h11, 'h10, 1, 1};
    tbl[7]  = '{1, 4, 'h22, 0, 0, 4, 5, 4, 'h22, 'h42, 'h22, 'h00, 0, 0};
    tbl[8]  = '{1, 6, 'h1, 1, 1, 6, 1, 6, 'h1, 0, 'h1, 'h02, 0, 1};
    tbl[9]  = '{0, 0, 0, 1, 1, 1, 6, 1, 0, 'h1, 0, 'h02, 1, 0};
    tbl[10] = '{1, 0, 'h5, 0, 0, 0, 1, 0, 'h5, 0, 'h5, 'h02, 0, 1};
    tbl[11] = '{1, 7, 'hCAFEF00D, 1, 7, 7, 0, 7, 'hCAFEF00D, 'h5, 'hCAFEF00D, 'h82, 1, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_a", b0.rd_data_a, 0);
    chk("reset_busy_vec", 32'(b0.busy_vec), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rda = 3'(tbl[i].a); rdb = 3'(tbl[i].b); dbg = 3'(tbl[i].d);
      apply(tbl[i].we[0], 3'(tbl[i].wa), tbl[i].wd, tbl[i].re[0], 3'(tbl[i].ra));
      chk($sformatf("row%0d_rd_a", i), b0.rd_data_a, tbl[i].ea);
      chk($sformatf("row%0d_rd_b", i), b0.rd_data_b, tbl[i].eb);
      chk($sformatf("row%0d_dbg", i), b0.dbg_data, tbl[i].ed);
      chk($sformatf("row%0d_busy_vec", i), 32'(b0.busy_vec), tbl[i].ebv);
      chk($sformatf("row%0d_busy_a", i), 32'(b0.busy_a), tbl[i].eba);
      chk($sformatf("row%0d_busy_b", i), 32'(b0.busy_b), tbl[i].ebb);
    end
    // Bypass: reg6=1 and reserved, same-cycle write of 0x99 observed before the edge.
    apply(1'b0, 3'd0, 32'd0, 1'b1, 3'd6);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h99; rdb = 3'd6; rda = 3'd2; dbg = 3'd6;
    #1;
    chk("byp_pre_rd_b", b0.rd_data_b, BYP ? 32'h99 : 32'h1);
    chk("byp_pre_busy_b", 32'(b0.busy_b), BYP ? 32'd0 : 32'd1);
    chk("byp_pre_dbg", b0.dbg_data, 32'h1);
    chk("byp_pre_rd_a", b0.rd_data_a, 32'h7);
    @(posedge clk);
    #1 wr_en = 1'b0;
    #1;
    chk("byp_post_rd_b", b0.rd_data_b, 32'h99);
    chk("byp_post_busy_b", 32'(b0.busy_b), 0);
    chk("byp_post_busy_vec", 32'(b0.busy_vec), 32'h82);
    // Zero-register / six-register instance.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF; rsv_en = 1'b1; rsv_addr = 3'd0; rda = 3'd0; dbg = 3'd0;
    #1;
    chk("z_pre_rd_a", b1.rd_data_a, 0);
    chk("z_pre_busy_a", 32'(b1.busy_a), 0);
    @(posedge clk);
    #1 wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("z_post_rd_a", b1.rd_data_a, 0);
    chk("z_post_dbg", b1.dbg_data, 0);
    chk("z_post_busy0", 32'(b1.busy_vec[0]), 0);
    rda = 3'd7; rdb = 3'd5; dbg = 3'd7;
    apply(1'b1, 3'd7, 32'h1234, 1'b1, 3'd7);
    chk("z_oor_rd_a", b1.rd_data_a, 0);
    chk("z_oor_busy_a", 32'(b1.busy_a), 0);
    chk("z_oor_dbg", b1.dbg_data, 0);
    chk("z_rd5", b1.rd_data_b, 32'h42);
    chk("z_busy_vec", 32'(b1.busy_vec), 32'h02);
    rdb = 3'd6;
    #1 chk("z_oor6_rd_b", b1.rd_data_b, 0);
    // Reset asserted in the middle of a write.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD; rda = 3'd3; rdb = 3'd2; dbg = 3'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_a", b0.rd_data_a, 0);
    chk("rst_rd_b", b0.rd_data_b, 0);
    chk("rst_dbg", b0.dbg_data, 0);
    chk("rst_busy_vec", 32'(b0.busy_vec), 0);
    chk("rst_busy_a", 32'(b0.busy_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1; wr_en = 1'b0;
    #1 chk("rst_rel_rd_a", b0.rd_data_a, 0);
    @(posedge clk);
    #1 chk("rst_after_rd_a", b0.rd_data_a, 0);
    chk("rst_after_busy_vec", 32'(b0.busy_vec), 0);
    // Randomized traffic on both instances against the rule model.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 1) == 1); wr_addr = 3'($urandom_range(0, 7)); wr_data = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = 3'($urandom_range(0, 7));
      rda = 3'($urandom_range(0, 7)); rdb = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      dbg = 3'($urandom_range(0, 7));
      #1;
      chk_model(0, n);
      chk_model(1, n);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (wr_en && okw(k, int'(wr_addr))) begin
          m_mem[k][wr_addr] = wr_data;
          m_busy[k][wr_addr] = 1'b0;
        end
        if (rsv_en && okw(k, int'(rsv_addr))) m_busy[k][rsv_addr] = 1'b1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc2k_regfile_sb.md
Name: lc2k_regfile_sb

Overview:
- Parametrised, clocked successor to the single-cycle LC2K register file, for the pipelined core.
- Provides two combinational read ports, one synchronous write port, an optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- A debug read port replaces the fixed reg1 tap.
- Sits between decode (reads, reserve) and writeback (write, clear).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 8, number of architectural registers (≥2).
- ADDR_W, $clog2(NUM_REGS), register index width.
- ZERO_REG0, 0, when 1: reg 0 reads 0, writes to it are dropped, and it is never busy.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  port A data, combinational.
- rd_data_b  out  DATA_W  port B data, combinational.
- busy_a  out  1  register at rd_addr_a has a pending write.
- busy_b  out  1  register at rd_addr_b has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback index.
- wr_data  in  DATA_W  writeback value.
- rsv_en  in  1  reserve destination (issue of add/nor/lw).
- rsv_addr  in  ADDR_W  destination to mark busy.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  debug read data, combinational, never bypassed.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset:
  - While rst_n=0, all registers=0 and all busy bits=0.
  - Consequently rd_data_a/b=0, dbg_data=0, busy_a/b=0, busy_vec=0.
  - Reset asserted mid-operation discards any write or reserve in that cycle.
- Write: on a rising clk with wr_en=1 and wr_addr<NUM_REGS, reg[wr_addr] ← wr_data. Visible to dbg_data from the next cycle.
- Read:
  - rd_data_x = reg[rd_addr_x], combinational, zero-cycle latency.
  - An index ≥ NUM_REGS reads 0 and its busy is 0.
- Scoreboard, per-register busy bit, updated on the rising edge:
  - wr_en to reg i clears busy[i].
  - rsv_en to reg i sets busy[i].
  - Reserve and write to the same reg in the same cycle: busy[i]=1 (the new reservation wins; the write still updates data).
  - Reserve to a reg that is already busy: busy stays 1, no error.
  - A write to a non-busy reg is legal; busy stays 0.
- ZERO_REG0=1:
  - rd_data=0 and dbg_data=0 for index 0.
  - Writes and reserves to index 0 are ignored; busy[0] is tied to 0.
- Out-of-range wr_addr or rsv_addr is ignored entirely.
- No internal state machine beyond the register array and scoreboard. All state is flops; no latches and no combinational write.

Optional Feature:
- Macro: LC2K_REGFILE_BYPASS_EN.
- Defined:
  - In the same cycle that wr_en=1 and wr_addr==rd_addr_x (in range, and not reg0 when ZERO_REG0=1), rd_data_x=wr_data and busy_x=0. Port A and port B are forwarded independently.
  - This resolves the read-after-writeback hazard within one cycle.
- Undefined:
  - rd_data_x shows the pre-write value until the next edge.
  - busy_x reflects the registered scoreboard only.
- dbg_data is unaffected in both modes.

Decomposition:
- Shared package lc2k_pkg:
  - LC2K_DATA_W=32, LC2K_NUM_REGS=8, LC2K_ADDR_W=3.
  - typedef reg_idx_t [LC2K_ADDR_W-1:0], typedef word_t [LC2K_DATA_W-1:0].
  - Opcode constants for users deciding rsv_en.
- One sub-module, lc2k_scoreboard (busy-bit array with set/clear priority), instantiated once. The data array and bypass muxes stay in the top module.

Test Plan:
- Reset: pulse rst_n low mid-write (wr_en=1, wr_addr=3, wr_data=0xDEAD) → all reads 0, busy_vec=0; after release, reg3 reads 0.
- Write/read: write reg2=0x0000_0007 at edge N → rd_addr_a=2 gives 0x7 after edge N; dbg_addr=2 gives 0x7.
- Scoreboard: rsv reg5 at edge N → busy_vec=8'b0010_0000, busy_a=1 with rd_addr_a=5. Write reg5=0x42 at edge N+3 → busy clears, reads 0x42.
- Simultaneous: reg4 busy; rsv_en+wr_en to reg4 at the same edge with data 0x11 → reg4=0x11, busy[4] stays 1.
- Bypass: reg6=0x1; same-cycle wr_en reg6=0x99 with rd_addr_b=6:
  - LC2K_REGFILE_BYPASS_EN defined → rd_data_b=0x99 before the edge.
  - Undefined → 0x1 before the edge, 0x99 after.
- ZERO_REG0=1: write reg0=0xFFFF_FFFF and rsv reg0 → rd_data_a=0 and busy_vec[0]=0. Rerun with NUM_REGS=6: wr_addr=7 is ignored, reads of index 7 return 0.
